// File: rtl/vga_scanout_if.sv
// Pixel bus between the scan-out stage, the frame memory read port and the VGA pins.
// The master is the scan-out stage; the slave is the memory / pin side.
interface vga_scanout_if;
  logic [9:0]  raddr_h_o;
  logic [8:0]  raddr_v_o;
  logic [23:0] vga_rdata_i;
  logic [7:0]  vga_r_o;
  logic [7:0]  vga_g_o;
  logic [7:0]  vga_b_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        frame_start_o;

  modport master (
    output raddr_h_o, raddr_v_o,
    input  vga_rdata_i,
    output vga_r_o, vga_g_o, vga_b_o, hsync_o, vsync_o, de_o, frame_start_o
  );

  modport slave (
    input  raddr_h_o, raddr_v_o,
    output vga_rdata_i,
    input  vga_r_o, vga_g_o, vga_b_o, hsync_o, vsync_o, de_o, frame_start_o
  );
endinterface

// File: rtl/vga_scanout.sv
// Raster timing generator and pixel fetch stage: walks the raster, addresses the frame
// memory and registers RGB, syncs and DE together one pixel after the address is shown.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  vga_scanout_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int D_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [D_W-1:0] D_LAST   = D_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic           SYNC_IDL = ~SYNC_POL;

  logic [D_W-1:0] div_q, div_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic [23:0]    rgb_q, rgb_d;
  logic           de_q, de_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           fs_q, fs_d;

  logic pix_tick;
  logic active;
  logic hs_zone;
  logic vs_zone;

  always_comb begin
    pix_tick = (div_q == D_LAST);
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_zone  = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_zone  = (v_q >= VS_BEG) && (v_q < VS_END);

    // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latch).
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    rgb_d = rgb_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;

    if (!en_i) begin
      // Disabled: abandon the frame and park in the same state reset produces.
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
      rgb_d = '0;
      de_d  = 1'b0;
      hs_d  = SYNC_IDL;
      vs_d  = SYNC_IDL;
    end else if (pix_tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // All pin outputs sample the same counter state, so they stay mutually aligned.
      rgb_d = active ? vga.vga_rdata_i : '0;
      de_d  = active;
      hs_d  = hs_zone ? SYNC_POL : SYNC_IDL;
      vs_d  = vs_zone ? SYNC_POL : SYNC_IDL;
      fs_d  = (h_q == '0) && (v_q == '0);
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= SYNC_IDL;
      vs_q  <= SYNC_IDL;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  // Blanking addresses are forced to 0 so the memory is never read outside the array.
  assign vga.raddr_h_o     = active ? 10'(h_q) : '0;
  assign vga.raddr_v_o     = active ? 9'(v_q) : '0;
  assign vga.vga_r_o       = rgb_q[23:16];
  assign vga.vga_g_o       = rgb_q[15:8];
  assign vga.vga_b_o       = rgb_q[7:0];
  assign vga.hsync_o       = hs_q;
  assign vga.vsync_o       = vs_q;
  assign vga.de_o          = de_q;
  assign vga.frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full 640x480 raster at one clk per pixel, plus a reduced raster
// at one and four clks per pixel so whole frames fit in a short run.
module tb_vga_scanout;

  localparam int S_HA  = 20;
  localparam int S_HFP = 4;
  localparam int S_HSY = 6;
  localparam int S_HBP = 5;
  localparam int S_VA  = 12;
  localparam int S_VFP = 2;
  localparam int S_VSY = 2;
  localparam int S_VBP = 3;

  typedef struct {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, div;
  } geom_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] en_v;
  geom_t      geo [3];
  logic [46:0] sb_q [$];
  logic [46:0] obs [3];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_scanout_if if_full ();
  vga_scanout_if if_small ();
  vga_scanout_if if_div4 ();

  vga_scanout #(.CLK_DIV(1)) u_full (
    .clk(clk), .rst(rst_v[0]), .en_i(en_v[0]), .vga(if_full)
  );

  vga_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
    .CLK_DIV(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst(rst_v[1]), .en_i(en_v[1]), .vga(if_small)
  );

  vga_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
    .CLK_DIV(4), .SYNC_POL(1'b0)
  ) u_div4 (
    .clk(clk), .rst(rst_v[2]), .en_i(en_v[2]), .vga(if_div4)
  );

  // Frame memory model: each pixel holds its own coordinates.
  assign if_full.vga_rdata_i  = {if_full.raddr_h_o[7:0],  if_full.raddr_v_o[7:0],  8'hA5};
  assign if_small.vga_rdata_i = {if_small.raddr_h_o[7:0], if_small.raddr_v_o[7:0], 8'hA5};
  assign if_div4.vga_rdata_i  = {if_div4.raddr_h_o[7:0],  if_div4.raddr_v_o[7:0],  8'hA5};

  // Observed bundle: {frame_start, de, hsync, vsync, rgb[23:0], addr_h[9:0], addr_v[8:0]}
  assign obs[0] = {if_full.frame_start_o, if_full.de_o, if_full.hsync_o, if_full.vsync_o,
                   if_full.vga_r_o, if_full.vga_g_o, if_full.vga_b_o,
                   if_full.raddr_h_o, if_full.raddr_v_o};
  assign obs[1] = {if_small.frame_start_o, if_small.de_o, if_small.hsync_o, if_small.vsync_o,
                   if_small.vga_r_o, if_small.vga_g_o, if_small.vga_b_o,
                   if_small.raddr_h_o, if_small.raddr_v_o};
  assign obs[2] = {if_div4.frame_start_o, if_div4.de_o, if_div4.hsync_o, if_div4.vsync_o,
                   if_div4.vga_r_o, if_div4.vga_g_o, if_div4.vga_b_o,
                   if_div4.raddr_h_o, if_div4.raddr_v_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bundle after enabled clk edge k (k = -1: idle/reset). Derived from the clk
  // count alone: pixel index = edges elapsed / div, raster position from the index.
  function automatic logic [46:0] exp_vec(input int idx, input int k);
    geom_t       g;
    int          ht, vt, pc, p, h, v, ch, cv;
    logic [31:0] hl, vl, chl, cvl;
    logic [23:0] rgb;
    logic        de, hs, vs, fs;
    logic [9:0]  ah;
    logic [8:0]  av;
    g   = geo[idx];
    ht  = g.ha + g.hfp + g.hsy + g.hbp;
    vt  = g.va + g.vfp + g.vsy + g.vbp;
    pc  = (k + 1) / g.div;
    ch  = pc % ht;
    cv  = (pc / ht) % vt;
    chl = ch;
    cvl = cv;
    ah  = '0;
    av  = '0;
    if (ch < g.ha && cv < g.va) begin
      ah = chl[9:0];
      av = cvl[8:0];
    end
    rgb = '0;
    de  = 1'b0;
    hs  = 1'b1;
    vs  = 1'b1;
    fs  = 1'b0;
    if (k + 1 >= g.div) begin
      p  = pc - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      hl = h;
      vl = v;
      de = (h < g.ha) && (v < g.va);
      if (de) rgb = {hl[7:0], vl[7:0], 8'hA5};
      hs = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsy));
      vs = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsy));
      fs = ((k + 1) % g.div == 0) && (h == 0) && (v == 0);
    end
    return {fs, de, hs, vs, rgb, ah, av};
  endfunction

  // One clk: push the expectation for this edge, pop and compare on the falling edge.
  task automatic cycle(input int idx, input int k, input string tag);
    logic [46:0] e;
    @(posedge clk);
    sb_q.push_back(exp_vec(idx, k));
    @(negedge clk);
    e = sb_q.pop_front();
    check(tag, 64'(obs[idx]), 64'(e));
  endtask

  initial begin
    int de_cnt, vs_cnt, hs_first, hs_last, fs1, fs2, bad;
    logic [45:0] prev;

    geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    geo[1] = '{S_HA, S_HFP, S_HSY, S_HBP, S_VA, S_VFP, S_VSY, S_VBP, 1};
    geo[2] = '{S_HA, S_HFP, S_HSY, S_HBP, S_VA, S_VFP, S_VSY, S_VBP, 4};
    rst_v = 3'b111;
    en_v  = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(i, -1, "reset_idle");

    // Full raster: three lines plus 300 pixels, then a 3-clk reset mid-line.
    rst_v[0] = 1'b0;
    en_v[0]  = 1'b1;
    de_cnt = 0; hs_first = -1; hs_last = -1;
    for (int k = 0; k < 2700; k++) begin
      cycle(0, k, "full_raster");
      if (k < 800) begin
        if (obs[0][45]) de_cnt++;
        if (!obs[0][44]) begin
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
      end
    end
    check("full_de_per_line", 64'(de_cnt), 64'd640);
    check("full_hsync_first", 64'(hs_first), 64'd656);
    check("full_hsync_last", 64'(hs_last), 64'd751);
    rst_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, -1, "full_rst_midline");
    rst_v[0] = 1'b0;
    for (int k = 0; k < 40; k++) cycle(0, k, "full_restart");
    rst_v[0] = 1'b1;

    // Reduced raster, one clk per pixel: two frames, then an enable drop at (h=10, v=5).
    rst_v[1] = 1'b0;
    en_v[1]  = 1'b1;
    de_cnt = 0; vs_cnt = 0; fs1 = -1; fs2 = -1;
    for (int k = 0; k < 1515; k++) begin
      cycle(1, k, "small_raster");
      if (k < 665) begin
        if (obs[1][45]) de_cnt++;
        if (!obs[1][43]) vs_cnt++;
      end
      if (obs[1][46]) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    check("small_de_per_frame", 64'(de_cnt), 64'd240);
    check("small_vsync_low", 64'(vs_cnt), 64'd70);
    check("small_fs_first", 64'(fs1), 64'd0);
    check("small_fs_period", 64'(fs2 - fs1), 64'd665);
    en_v[1] = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1, -1, "toggle_idle");
    en_v[1] = 1'b1;
    cycle(1, 0, "toggle_restart");
    check("toggle_fs", 64'(obs[1][46]), 64'd1);
    check("toggle_rgb", 64'(obs[1][42:19]), 64'h0000A5);
    for (int k = 1; k < 100; k++) cycle(1, k, "toggle_raster");
    rst_v[1] = 1'b1;

    // Reduced raster, four clks per pixel: two frames.
    rst_v[2] = 1'b0;
    en_v[2]  = 1'b1;
    prev = obs[2][45:0];
    bad = 0; fs1 = -1; fs2 = -1;
    for (int k = 0; k < 5330; k++) begin
      cycle(2, k, "div4_raster");
      if (obs[2][45:0] !== prev && (k % 4) != 3) bad++;
      prev = obs[2][45:0];
      if (obs[2][46]) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    check("div4_off_tick_changes", 64'(bad), 64'd0);
    check("div4_fs_first", 64'(fs1), 64'd3);
    check("div4_fs_period", 64'(fs2 - fs1), 64'd2660);
    rst_v[2] = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
